// File: rtl/sender_tx_serializer_if.sv
// sender_tx_serializer_if: the serializer's control, memory and serial signals in one bundle.
// The master modport belongs to the serializer. The slave modport belongs to the side
// that drives Start/WordCount/RxReady/MemData and observes everything else.
interface sender_tx_serializer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              Start;
    logic [ADDR_W:0]   WordCount;
    logic              RxReady;
    logic [DATA_W-1:0] MemData;
    logic              ReadEnable;
    logic              WriteEnable;
    logic [ADDR_W-1:0] Address;
    logic              TxData;
    logic              TxValid;
    logic              Busy;
    logic              Done;

    modport master (
        input  Start, WordCount, RxReady, MemData,
        output ReadEnable, WriteEnable, Address, TxData, TxValid, Busy, Done
    );

    modport slave (
        output Start, WordCount, RxReady, MemData,
        input  ReadEnable, WriteEnable, Address, TxData, TxValid, Busy, Done
    );
endinterface

// File: rtl/sender_tx_serializer.sv
// sender_tx_serializer: reads WordCount words from the sender memory, starting at address 0.
// Each word is shifted out MSB-first on TxData. Each bit is held BIT_DIV clocks.
// A word only starts once RxReady is seen high.
// Optional feature macro SENDER_TX_PARITY_EN: when defined, an even-parity bit follows
// each word's data bits.
module sender_tx_serializer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int MEM_LAT = 2,
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    sender_tx_serializer_if.master bus
);

`ifdef SENDER_TX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BIT_W = $clog2(NBITS);
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LAT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RDY,
        SHIFT,
        NEXT,
        DONE
    } state_t;

    state_t            r_state;
    logic              r_readEnable;
    logic [ADDR_W-1:0] r_address;
    logic              r_txData;
    logic              r_txValid;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_sent;
    logic [LAT_W-1:0]  r_latCnt;
    logic [DIV_W-1:0]  r_divCnt;
    logic [BIT_W-1:0]  r_bitCnt;
`ifdef SENDER_TX_PARITY_EN
    logic              r_parity;
`endif

    logic [CNT_W-1:0]  w_countSat;
    logic [CNT_W-1:0]  w_sentNext;
    logic              w_nextBit;

    // A request for more words than the memory holds is clamped to one full pass.
    assign w_countSat = (bus.WordCount > MAX_WORDS) ? MAX_WORDS : bus.WordCount;
    assign w_sentNext = r_sent + CNT_W'(1);

    // The register already holds the bit that goes out next.
    // With parity enabled, the parity bit replaces the data bit after the last data bit.
`ifdef SENDER_TX_PARITY_EN
    assign w_nextBit = (r_bitCnt == BIT_W'(DATA_W - 1)) ? r_parity : r_shreg[DATA_W-2];
`else
    assign w_nextBit = r_shreg[DATA_W-2];
`endif

    assign bus.ReadEnable  = r_readEnable;
    assign bus.WriteEnable = 1'b0;
    assign bus.Address     = r_address;
    assign bus.TxData      = r_txData;
    assign bus.TxValid     = r_txValid;
    assign bus.Busy        = r_busy;
    assign bus.Done        = r_done;

    // Transfer sequencer: fetch a word, wait for the receiver, shift the bits, advance.
    // Every output is a register, and it is set when the state it belongs to is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_readEnable <= 1'b0;
            r_address    <= '0;
            r_txData     <= 1'b0;
            r_txValid    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_shreg      <= '0;
            r_count      <= '0;
            r_sent       <= '0;
            r_latCnt     <= '0;
            r_divCnt     <= '0;
            r_bitCnt     <= '0;
`ifdef SENDER_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Start) begin
                        r_address <= '0;
                        if (bus.WordCount == '0) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_count      <= w_countSat;
                            r_sent       <= '0;
                            r_busy       <= 1'b1;
                            r_readEnable <= 1'b1;
                            r_latCnt     <= '0;
                            r_state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (r_latCnt == LAT_LAST) begin
                        r_shreg      <= bus.MemData;
`ifdef SENDER_TX_PARITY_EN
                        r_parity     <= ^bus.MemData;
`endif
                        r_readEnable <= 1'b0;
                        r_state      <= WAIT_RDY;
                    end else begin
                        r_latCnt <= r_latCnt + LAT_W'(1);
                    end
                end
                WAIT_RDY: begin
                    if (bus.RxReady) begin
                        r_txValid <= 1'b1;
                        r_txData  <= r_shreg[DATA_W-1];
                        r_divCnt  <= '0;
                        r_bitCnt  <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_divCnt == DIV_LAST) begin
                        r_divCnt <= '0;
                        r_shreg  <= r_shreg << 1;
                        if (r_bitCnt == BIT_LAST) begin
                            r_txValid <= 1'b0;
                            r_txData  <= 1'b0;
                            r_state   <= NEXT;
                        end else begin
                            r_bitCnt <= r_bitCnt + BIT_W'(1);
                            r_txData <= w_nextBit;
                        end
                    end else begin
                        r_divCnt <= r_divCnt + DIV_W'(1);
                    end
                end
                NEXT: begin
                    r_sent    <= w_sentNext;
                    r_address <= r_address + ADDR_W'(1);
                    if (w_sentNext == r_count) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_readEnable <= 1'b1;
                        r_latCnt     <= '0;
                        r_state      <= FETCH;
                    end
                end
                DONE: begin
                    r_address <= '0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sender_tx_serializer.md
Name: sender_tx_serializer

Overview:
Downstream consumer of the sender's 16x16 word memory. On a Start pulse it reads WordCount words from the memory, beginning at address 0, using the memory's ReadEnable/Address/DataOut interface. Each word is shifted out MSB-first on a single serial line towards the receiver side. Each word is gated by the receiver's RxReady level.

Parameters:
DATA_W, 16, memory word width and bits per serial word
ADDR_W, 4, memory address width (16 words)
MEM_LAT, 2, clocks from ReadEnable rising to a valid MemData sample (min 1)
BIT_DIV, 4, clocks each serial bit is held on TxData (min 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Start  in  1  single-cycle request to begin a transfer
WordCount  in  ADDR_W+1  number of words to send (0..16)
RxReady  in  1  receiver can accept the next word (level)
MemData  in  DATA_W  memory DataOut
ReadEnable  out  1  memory read request
WriteEnable  out  1  memory write request, held 0
Address  out  ADDR_W  memory address
TxData  out  1  serial data, MSB first
TxValid  out  1  high while a data bit is on TxData
Busy  out  1  transfer in progress
Done  out  1  one-cycle pulse at transfer end

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs are 0: ReadEnable, WriteEnable, Address, TxData, TxValid, Busy and Done.
  - Internal counters and the shift register are cleared.
  - Reset takes effect immediately, mid-word or mid-read; no partial word is completed.
- Registered FSM with states IDLE, FETCH, WAIT_RDY, SHIFT, NEXT, DONE. All outputs are registered.
- IDLE:
  - Busy=0.
  - Start=1 with WordCount=0: go to DONE, producing a Done pulse with no reads.
  - Start=1 with WordCount>16: WordCount saturates to 16.
  - Otherwise Start=1: latch the count, set Address=0, set Busy=1, go to FETCH.
- FETCH:
  - ReadEnable=1 and Address held for MEM_LAT cycles.
  - On the last cycle, MemData is captured into the shift register.
  - ReadEnable returns to 0 on entry to WAIT_RDY.
- WAIT_RDY: stay until RxReady=1, then go to SHIFT. The shift register is held.
- SHIFT:
  - TxValid=1 and TxData=shreg[DATA_W-1].
  - Each bit is held for exactly BIT_DIV clocks, then shreg shifts left by 1.
  - After DATA_W bits, go to NEXT; TxValid and TxData drop to 0 the same cycle.
  - RxReady is sampled only in WAIT_RDY. Dropping RxReady mid-word does not stall the word.
- NEXT (1 cycle):
  - Increment the sent-word counter and Address.
  - If sent == count, go to DONE; else go to FETCH.
  - After word 16, Address wraps 15 -> 0.
- DONE: Done=1 for one cycle, Busy=0, go to IDLE. Address returns to 0.
- Start while Busy=1 is ignored, including Start in the DONE cycle.
- Serial cycles per word = DATA_W*BIT_DIV. Per-word overhead = MEM_LAT + 1 (NEXT) + at least 1 (WAIT_RDY).
- WriteEnable is a constant 0 so the memory never enters WRITE.

Optional Feature:
SENDER_TX_PARITY_EN
- Defined:
  - After the DATA_W data bits, one extra even-parity bit (XOR of the word) is sent, held BIT_DIV clocks with TxValid=1.
  - A word then takes (DATA_W+1)*BIT_DIV clocks.
- Undefined: no parity bit; exactly DATA_W bits per word.

Test Plan:
- Reset mid-SHIFT of word 2: pull rst_n low -> all outputs 0 the same cycle (asynchronously); after release, Busy=0 until the next Start.
- Memory preloaded with mem[0]=16'hA5C3, RxReady=1, Start with WordCount=1 (BIT_DIV=4, MEM_LAT=2):
  - ReadEnable high 2 cycles at Address 0.
  - TxData sequence 1010010111000011, each bit held 4 cycles with TxValid=1.
  - Done pulses once; Busy falls.
- WordCount=3, mem[0..2]=16'h0001, 16'h8000, 16'hFFFF; RxReady held 0 for 10 cycles after each fetch -> three words sent in address order 0,1,2; no TxValid while RxReady=0.
- Limit cases:
  - WordCount=0 -> Done pulse, no ReadEnable.
  - WordCount=20 -> exactly 16 words sent; Address wraps to 0 at the end.
- Start pulsed during an active transfer -> ignored; word count and data unchanged.
- With SENDER_TX_PARITY_EN, word 16'h0007 -> 17th bit = 1; word 16'h0003 -> 17th bit = 0.
